// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
//   Shared definitions for the SPI target: default frame length, FSM state
//   encoding and the bit-counter width helper.
// -----------------------------------------------------------------------------
package spi_pkg;

  localparam int LEN_SPI_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // waiting for chip select
    ST_SHIFT = 2'd1,  // frame in progress, bits moving on MOSI/MISO
    ST_HOLD  = 2'd2   // full word taken, waiting for chip select release
  } spi_state_t;

  // Counter must hold 0..len inclusive.
  function automatic int cnt_width(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
//   Multi-flop synchronizer for one asynchronous pin followed by a history
//   flop that yields single-cycle rise/fall strobes in the CLK domain.
//
//   CLK   in   local clock
//   RST   in   synchronous reset, active high
//   d     in   asynchronous pin
//   q     out  synchronised level
//   rise  out  one-cycle strobe on 0->1 of q
//   fall  out  one-cycle strobe on 1->0 of q
// -----------------------------------------------------------------------------
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              prev;

  // NOTE: sequential state uses non-blocking assignment so every flop in the
  // chain samples the value from before this edge, not its neighbour's update.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync <= {STAGES{RESET_VAL}};
      prev <= RESET_VAL;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      prev <= sync[STAGES-1];
    end
  end

  assign q    = sync[STAGES-1];
  assign rise =  q & ~prev;
  assign fall = ~q &  prev;

endmodule

// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//   SPI target for a mode with SCLK idle high, data launched on SCLK rise and
//   sampled on SCLK fall. All pins are oversampled in the CLK domain. The
//   received word is committed to a held RX register with a valid/ready
//   handshake; a preloaded TX word is shifted back on MISO.
//
//   CLK        in   local clock
//   RST        in   synchronous reset, active high
//   SPI_SCLK   in   SPI clock, idle high
//   SPI_CSN    in   chip select, active low
//   SPI_MOSI   in   master-out data
//   SPI_MISO   out  slave-out data, 0 whenever no frame is shifting
//   TX_DATA    in   word returned in the next frame
//   TX_WE      in   load TX_DATA into the TX holding register
//   RX_DATA    out  last committed word
//   RX_VALID   out  RX_DATA holds an unconsumed word
//   RX_READY   in   consumer accepts RX_DATA
//   RX_OVERRUN out  pulse: frame completed while RX_VALID was still set
//   FRAME_ERR  out  pulse: chip select released before LEN_SPI bits
//   BUSY       out  synchronised chip select is low
// -----------------------------------------------------------------------------
module spi_slave
  import spi_pkg::*;
#(
  parameter int LEN_SPI     = LEN_SPI_DEFAULT,
  parameter bit LSB_FIRST   = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               SPI_SCLK,
  input  logic               SPI_CSN,
  input  logic               SPI_MOSI,
  output logic               SPI_MISO,
  input  logic [LEN_SPI-1:0] TX_DATA,
  input  logic               TX_WE,
  output logic [LEN_SPI-1:0] RX_DATA,
  output logic               RX_VALID,
  input  logic               RX_READY,
  output logic               RX_OVERRUN,
  output logic               FRAME_ERR,
  output logic               BUSY
);

  localparam int             CW       = cnt_width(LEN_SPI);
  localparam logic [CW-1:0]  LAST_BIT = CW'(LEN_SPI - 1);
  // Cycles for the synchronizers to flush their reset value after RST.
  localparam int             SETTLE   = SYNC_STAGES + 2;

  // ---------------------------------------------------------------------------
  // Pin synchronisation and edge strobes
  // ---------------------------------------------------------------------------
  logic sclk_q, sclk_rise, sclk_fall;
  logic csn_q, csn_rise, csn_fall;
  logic mosi_q, mosi_rise, mosi_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sclk (
    .CLK (CLK), .RST (RST), .d (SPI_SCLK),
    .q   (sclk_q), .rise (sclk_rise), .fall (sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_csn (
    .CLK (CLK), .RST (RST), .d (SPI_CSN),
    .q   (csn_q), .rise (csn_rise), .fall (csn_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .CLK (CLK), .RST (RST), .d (SPI_MOSI),
    .q   (mosi_q), .rise (mosi_rise), .fall (mosi_fall)
  );

  // Only the level of MOSI and the edges of SCLK are needed.
  logic unused_sync;
  assign unused_sync = sclk_q ^ mosi_rise ^ mosi_fall;

  assign BUSY = ~csn_q;

  // ---------------------------------------------------------------------------
  // Start qualification
  //   The CSN synchronizer resets to "deselected". If RST is released while
  //   the master holds CSN low, the flushing chain produces a false csn_fall.
  //   A frame may only start once CSN has been observed high after reset.
  // ---------------------------------------------------------------------------
  logic [SETTLE-1:0] settle;
  logic              settled;
  logic              armed;
  logic              start;

  always_ff @(posedge CLK) begin
    if (RST) begin
      settle <= '0;
      armed  <= 1'b0;
    end else begin
      settle <= {settle[SETTLE-2:0], 1'b1};
      if (settled && csn_q) armed <= 1'b1;
    end
  end

  assign settled = settle[SETTLE-1];
  assign start   = csn_fall & armed;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  spi_state_t        state, next_state;
  logic [CW-1:0]     bit_cnt;
  logic              commit_c;
  logic              frame_err_c;

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= next_state;
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state  = state;
    commit_c    = 1'b0;
    frame_err_c = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) next_state = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (csn_rise) begin
          next_state  = ST_IDLE;
          frame_err_c = 1'b1;
        end else if (sclk_fall && bit_cnt == LAST_BIT) begin
          next_state = ST_HOLD;
          commit_c   = 1'b1;
        end
      end
      ST_HOLD: begin
        if (csn_rise) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shift datapath
  // ---------------------------------------------------------------------------
  logic [LEN_SPI-1:0] tx_hold;
  logic [LEN_SPI-1:0] tx_shift;
  logic [LEN_SPI-1:0] rx_shift;
  logic [LEN_SPI-1:0] rx_next;
  logic [LEN_SPI-1:0] tx_adv;
  logic               miso_bit;

  // First bit received ends up at bit 0 for LSB-first, at the MSB otherwise.
  assign rx_next  = LSB_FIRST ? {mosi_q, rx_shift[LEN_SPI-1:1]}
                              : {rx_shift[LEN_SPI-2:0], mosi_q};
  assign tx_adv   = LSB_FIRST ? {1'b0, tx_shift[LEN_SPI-1:1]}
                              : {tx_shift[LEN_SPI-2:0], 1'b0};
  assign miso_bit = LSB_FIRST ? tx_shift[0] : tx_shift[LEN_SPI-1];

  // First bit is on the pin as soon as SHIFT is entered; the master samples
  // it on the first SCLK fall, so no rising edge precedes it.
  assign SPI_MISO = (state == ST_SHIFT) & miso_bit;

  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_hold  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt  <= '0;
    end else begin
      if (TX_WE) tx_hold <= TX_DATA;

      if (state == ST_IDLE && start) begin
        // A write landing on the start cycle must already be in this frame.
        tx_shift <= TX_WE ? TX_DATA : tx_hold;
        bit_cnt  <= '0;
      end else if (state == ST_SHIFT && !csn_rise) begin
        if (sclk_fall) begin
          rx_shift <= rx_next;
          bit_cnt  <= bit_cnt + 1'b1;
        end
        // The rise before any fall would discard bit 0 unseen.
        if (sclk_rise && bit_cnt != '0) tx_shift <= tx_adv;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // RX holding register and status pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      RX_DATA    <= '0;
      RX_VALID   <= 1'b0;
      RX_OVERRUN <= 1'b0;
      FRAME_ERR  <= 1'b0;
    end else begin
      RX_OVERRUN <= 1'b0;
      FRAME_ERR  <= frame_err_c;
      if (commit_c) begin
        // A consume in the commit cycle frees the slot for the new word.
        if (!RX_VALID || RX_READY) begin
          RX_DATA  <= rx_next;
          RX_VALID <= 1'b1;
        end else begin
          RX_OVERRUN <= 1'b1;
        end
      end else if (RX_VALID && RX_READY) begin
        RX_VALID <= 1'b0;
      end
    end
  end

endmodule
